ysyx_22051013_ifu_fetch: RTL and testbench
==========================================

# ysyx_22051013_ifu_fetch

Instruction fetch unit: producer side of the IF/ID pipeline register. It owns the fetch PC, issues one instruction-memory request at a time, and buffers the returned instruction. It presents `if_inst`/`if_pc`/`bpu_jump`/`bpu_addr` to the IF/ID register, obeys the same `ifid_stall`, and accepts redirects from execute/flush logic.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: first fetch address after reset.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `redirect_valid` input 1: flush/redirect request, same cycle as IF/ID `ifid_flush`.
- `redirect_pc` input 64: new fetch PC when `redirect_valid`=1.
- `ifid_stall` input 1: downstream stall; buffered instruction is not consumed.
- `imem_req_valid` output 1: request pending.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_req_addr` output 64: request address, 4-byte aligned.
- `imem_rsp_valid` input 1: response beat, exactly one per accepted request, at least 1 cycle after acceptance.
- `imem_rsp_data` input 32: returned instruction.
- `if_valid` output 1: `if_*` holds a real instruction.
- `if_inst` output 32: instruction, 0 when `if_valid`=0.
- `if_pc` output 64: instruction PC, 0 when `if_valid`=0.
- `bpu_jump` output 1: prediction taken for `if_inst`.
- `bpu_addr` output 5: rd field of the predicted jump, 0 otherwise.

## Operation
- States: REQ, WAIT, HOLD, DROP. Reset state REQ; `pc` = `RESET_PC`.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_ready`, go to WAIT.
- WAIT: on `imem_rsp_valid`, capture data/`pc`/prediction into the output buffer and go to HOLD.
- HOLD: `if_valid`=1. If `ifid_stall`=0, the instruction is consumed this cycle: `pc` becomes next-PC and the state goes to REQ. If `ifid_stall`=1, all outputs hold.
- Next-PC is `pc`+4, or the predicted target when `bpu_jump`=1. 64-bit wrap-around arithmetic.
- DROP: the in-flight response is for a stale PC. On `imem_rsp_valid`, discard it and go to REQ.
- Redirect has highest priority over stall and consumption in every state:
  - `pc` is set to `{redirect_pc[63:2],2'b00}` and the output buffer is cleared.
  - From REQ without ready, or from HOLD: go to REQ.
  - From REQ with ready in the same cycle: go to DROP.
  - From WAIT with no response: go to DROP.
  - From WAIT with a response in the same cycle: discard it and go to REQ.
  - From DROP: stay in DROP; if a response arrives in the same cycle, discard it and go to REQ.
- Only one request is outstanding; `imem_req_valid` is never asserted in WAIT, HOLD or DROP.

## Timing
- Reset values: `imem_req_valid`=1 once reset deasserts (0 during `rst`), `imem_req_addr`=`RESET_PC`, `if_valid`=0, `if_inst`=0, `if_pc`=0, `bpu_jump`=0, `bpu_addr`=0.
- Reset asserted mid-operation: immediate return to REQ with reset values. A response arriving after reset for the pre-reset request is a system error and is not handled.
- Latency: request accepted at cycle T, response at T+k (k≥1), `if_valid`=1 from T+k+1.
- After consumption at cycle C, the next request is issued at C+1. With a zero-wait memory, sustained throughput is 1 instruction per 3 cycles. This is acceptable for the current core.
- Redirect at cycle R: `if_valid`=0 at R+1, and the redirect PC request is issued at R+1 unless the state is DROP.
- Outputs are registered; no combinational path exists from `imem_rsp_*` to `if_*`.

## Configuration
- `YSYX_22051013_IFU_BPU_EN` defined:
  - A predecoder on `imem_rsp_data` detects JAL (opcode 7'b1101111).
  - On JAL, `bpu_jump`=1, `bpu_addr`=inst[11:7], target = `pc` + sign-extended J-immediate, and next-PC is the target.
- Not defined: `bpu_jump`=0, `bpu_addr`=0, and next-PC is always `pc`+4.

## Test plan
- Reset, memory always ready, 1-cycle response, `ifid_stall`=0:
  - First request address is 0x8000_0000.
  - `if_pc` sequence is 0x8000_0000, 0x8000_0004, 0x8000_0008, with `if_valid` high 1 of every 3 cycles.
- `ifid_stall` held high for 5 cycles in HOLD -> `if_inst`/`if_pc` unchanged and no new request. The request for `pc`+4 is issued the cycle after the stall drops.
- Redirect to 0x8000_0103 in WAIT, stale response 3 cycles later -> stale data never appears on `if_*`, and the next request address is 0x8000_0100.
- Redirect in the same cycle as `imem_rsp_valid` in WAIT -> response discarded, `if_valid`=0, and a request to the redirect PC is issued the next cycle.
- With `YSYX_22051013_IFU_BPU_EN`, fetch of 0x0100_00EF (jal x1,+16) at 0x8000_0000 -> `bpu_jump`=1, `bpu_addr`=1, and the next request is 0x8000_0010. Without the macro, `bpu_jump`=0 and the next request is 0x8000_0004.
- `rst` pulsed while in WAIT -> all outputs return to reset values asynchronously, and a new request to `RESET_PC` is issued after `rst` deasserts.

Source files
------------

// File: rtl/ysyx_22051013_ifu_fetch_if.sv
// ysyx_22051013_ifu_fetch_if: fetch-unit bundle (redirect, stall, imem req/rsp, IF/ID outputs); master = fetch unit, slave = environment
interface ysyx_22051013_ifu_fetch_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ifid_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        bpu_jump;
  logic [4:0]  bpu_addr;
  modport master (
    input  redirect_valid, redirect_pc, ifid_stall, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, bpu_jump, bpu_addr
  );
  modport slave (
    output redirect_valid, redirect_pc, ifid_stall, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, bpu_jump, bpu_addr
  );
endinterface

// File: rtl/ysyx_22051013_ifu_fetch.sv
// ysyx_22051013_ifu_fetch: single-outstanding fetch FSM feeding IF/ID; ports clk, rst (async high), bus (master); JAL predecode under YSYX_22051013_IFU_BPU_EN
module ysyx_22051013_ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic clk,
  input logic rst,
  ysyx_22051013_ifu_fetch_if.master bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t state, state_n;
  logic [63:0] pc, nxt_q, ipc, nxt;
  logic [31:0] inst;
  logic [4:0]  rd;
  logic        v, jmp, jal, redir, rsp, capture, consume;
  assign redir = bus.redirect_valid;
  assign rsp   = bus.imem_rsp_valid;
`ifdef YSYX_22051013_IFU_BPU_EN
  assign jal = bus.imem_rsp_data[6:0] == 7'b1101111;
  assign nxt = jal ? pc + {{44{bus.imem_rsp_data[31]}}, bus.imem_rsp_data[19:12], bus.imem_rsp_data[20],
                           bus.imem_rsp_data[30:21], 1'b0} : pc + 64'd4;
`else
  assign jal = 1'b0;
  assign nxt = pc + 64'd4;
`endif
  assign capture = state == S_WAIT && rsp && !redir;
  assign consume = state == S_HOLD && !bus.ifid_stall && !redir;
  always_comb begin
    state_n = state;
    unique case (state)
      S_REQ:  state_n = bus.imem_req_ready ? (redir ? S_DROP : S_WAIT) : S_REQ;
      S_WAIT: state_n = rsp ? (redir ? S_REQ : S_HOLD) : (redir ? S_DROP : S_WAIT);
      S_HOLD: state_n = (redir || !bus.ifid_stall) ? S_REQ : S_HOLD;
      S_DROP: state_n = rsp ? S_REQ : S_DROP;
      default: state_n = S_REQ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      nxt_q <= '0;
      v     <= 1'b0;
      inst  <= '0;
      ipc   <= '0;
      jmp   <= 1'b0;
      rd    <= '0;
    end else begin
      state <= state_n;
      if (redir) pc <= bus.redirect_pc & ~64'h3;
      else if (consume) pc <= nxt_q;
      if (redir || consume) begin
        v    <= 1'b0;
        inst <= '0;
        ipc  <= '0;
        jmp  <= 1'b0;
        rd   <= '0;
      end else if (capture) begin
        v     <= 1'b1;
        inst  <= bus.imem_rsp_data;
        ipc   <= pc;
        jmp   <= jal;
        rd    <= jal ? bus.imem_rsp_data[11:7] : 5'd0;
        nxt_q <= nxt;
      end
    end
  end
  assign bus.imem_req_valid = state == S_REQ && !rst;
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = v;
  assign bus.if_inst        = inst;
  assign bus.if_pc          = ipc;
  assign bus.bpu_jump       = jmp;
  assign bus.bpu_addr       = rd;
endmodule

// File: tb/tb_ysyx_22051013_ifu_fetch.sv
// tb_ysyx_22051013_ifu_fetch: directed checks of fetch sequencing, stall, redirect, prediction and async reset
module tb_ysyx_22051013_ifu_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  ysyx_22051013_ifu_fetch_if bus();
  ysyx_22051013_ifu_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic accept();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
  endtask
  task automatic respond(input logic [31:0] d);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = d;
    step();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
  endtask
  initial begin
    logic [63:0] exp_nxt;
    logic        exp_j;
    logic [4:0]  exp_rd;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.ifid_stall     = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    step();
    chk("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("rst_if_valid", {63'd0, bus.if_valid}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("req_valid_after_rst", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("first_addr", bus.imem_req_addr, 64'h8000_0000);
    chk("if_inst_reset", {32'd0, bus.if_inst}, 64'd0);
    chk("if_pc_reset", bus.if_pc, 64'd0);
    chk("bpu_jump_reset", {63'd0, bus.bpu_jump}, 64'd0);
    chk("bpu_addr_reset", {59'd0, bus.bpu_addr}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("seq_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
      chk("seq_addr", bus.imem_req_addr, 64'h8000_0000 + 64'(4 * i));
      accept();
      chk("seq_wait_noreq", {63'd0, bus.imem_req_valid}, 64'd0);
      chk("seq_wait_invalid", {63'd0, bus.if_valid}, 64'd0);
      respond(32'h0000_0013 | (32'(i) << 20));
      chk("seq_valid", {63'd0, bus.if_valid}, 64'd1);
      chk("seq_pc", bus.if_pc, 64'h8000_0000 + 64'(4 * i));
      chk("seq_inst", {32'd0, bus.if_inst}, {32'd0, 32'h0000_0013 | (32'(i) << 20)});
      step();
      chk("seq_consumed", {63'd0, bus.if_valid}, 64'd0);
    end
    accept();
    respond(32'h00a0_0093);
    bus.ifid_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {63'd0, bus.if_valid}, 64'd1);
      chk("stall_pc", bus.if_pc, 64'h8000_000C);
      chk("stall_inst", {32'd0, bus.if_inst}, 64'h00a0_0093);
      chk("stall_noreq", {63'd0, bus.imem_req_valid}, 64'd0);
    end
    bus.ifid_stall = 1'b0;
    step();
    chk("unstall_req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("unstall_addr", bus.imem_req_addr, 64'h8000_0010);
    accept();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0103;
    step();
    bus.redirect_valid = 1'b0;
    chk("drop_invalid", {63'd0, bus.if_valid}, 64'd0);
    chk("drop_noreq", {63'd0, bus.imem_req_valid}, 64'd0);
    step();
    step();
    respond(32'hdead_beef);
    chk("stale_invalid", {63'd0, bus.if_valid}, 64'd0);
    chk("stale_inst", {32'd0, bus.if_inst}, 64'd0);
    chk("redir_req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("redir_addr", bus.imem_req_addr, 64'h8000_0100);
    accept();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0200;
    respond(32'h0000_0013);
    bus.redirect_valid = 1'b0;
    chk("same_cyc_invalid", {63'd0, bus.if_valid}, 64'd0);
    chk("same_cyc_req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("same_cyc_addr", bus.imem_req_addr, 64'h8000_0200);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0000;
    step();
    bus.redirect_valid = 1'b0;
    chk("req_redir_addr", bus.imem_req_addr, 64'h8000_0000);
    accept();
    respond(32'h0100_00EF);
`ifdef YSYX_22051013_IFU_BPU_EN
    exp_j = 1'b1; exp_rd = 5'd1; exp_nxt = 64'h8000_0010;
`else
    exp_j = 1'b0; exp_rd = 5'd0; exp_nxt = 64'h8000_0004;
`endif
    chk("jal_valid", {63'd0, bus.if_valid}, 64'd1);
    chk("jal_bpu_jump", {63'd0, bus.bpu_jump}, {63'd0, exp_j});
    chk("jal_bpu_addr", {59'd0, bus.bpu_addr}, {59'd0, exp_rd});
    step();
    chk("jal_next_addr", bus.imem_req_addr, exp_nxt);
    accept();
    respond(32'h0000_0013);
    step();
    accept();
    #2;
    rst = 1'b1;
    #1;
    chk("async_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("async_addr", bus.imem_req_addr, 64'h8000_0000);
    chk("async_if_valid", {63'd0, bus.if_valid}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("post_rst_addr", bus.imem_req_addr, 64'h8000_0000);
    accept();
    respond(32'h0000_0113);
    chk("post_rst_pc", bus.if_pc, 64'h8000_0000);
    chk("post_rst_inst", {32'd0, bus.if_inst}, 64'h0000_0113);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
